// File: rtl/regfile_mp_sb_if.sv
// Decode/writeback-side bus of the multi-port register file with scoreboard.
// master: decode/writeback pipeline stages; slave: the register file.
interface regfile_mp_sb_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*WIDTH-1:0]  rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_RD-1:0]        rd_en;
  logic                     we;
  logic [ADDR_W-1:0]        wa;
  logic [WIDTH-1:0]         wd;
  logic                     iss_valid;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     stall;
  logic [ADDR_W:0]          busy_cnt;

  modport master (
    output rd_addr, rd_en, we, wa, wd, iss_valid, iss_addr,
    input  rd_data, rd_busy, stall, busy_cnt
  );

  modport slave (
    input  rd_addr, rd_en, we, wa, wd, iss_valid, iss_addr,
    output rd_data, rd_busy, stall, busy_cnt
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with hardwired zero register and a per-register
// busy scoreboard (set at issue, cleared at writeback) driving the stall flag.
// Optional macro REGFILE_WB_BYPASS_EN: forward the writeback data/busy-clear to
// read ports in the same cycle.
module regfile_mp_sb #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input logic           clk,
  input logic           rst,
  regfile_mp_sb_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  logic [WIDTH-1:0]             mem_q [DEPTH];
  logic [DEPTH-1:0]             busy_q, busy_d;
  logic [ADDR_W:0]              cnt_q, cnt_d;
  logic                         set_en, clr_en, inc, dec;
  logic [NUM_RD-1:0][WIDTH-1:0] rdata;
  logic [NUM_RD-1:0]            rbusy;
  logic [ADDR_W-1:0]            ra;

  // Register 0 is neither written nor marked busy when hardwired to zero.
  assign set_en = bus.iss_valid && !((ZERO_REG != 0) && (bus.iss_addr == '0));
  assign clr_en = bus.we        && !((ZERO_REG != 0) && (bus.wa == '0));

  // Scoreboard next state; a same-cycle issue wins over the writeback clear.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[bus.wa]       = 1'b0;
    if (set_en) busy_d[bus.iss_addr] = 1'b1;
    inc   = set_en && !busy_q[bus.iss_addr];
    dec   = clr_en && busy_q[bus.wa] && !(set_en && (bus.iss_addr == bus.wa));
    cnt_d = cnt_q + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};
  end

  // Scoreboard bits and incremental busy counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Register storage, written at writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
    end else if (clr_en) begin
      mem_q[bus.wa] <= bus.wd;
    end
  end

  // Combinational read ports; zero-register and reset override everything.
  always_comb begin
    ra    = '0;
    rdata = '0;
    rbusy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra       = bus.rd_addr[k*ADDR_W +: ADDR_W];
      rdata[k] = mem_q[ra];
      rbusy[k] = busy_q[ra];
`ifdef REGFILE_WB_BYPASS_EN
      if (bus.we && (bus.wa == ra)) begin
        rdata[k] = bus.wd;
        rbusy[k] = bus.iss_valid && (bus.iss_addr == ra);
      end
`endif
      if (((ZERO_REG != 0) && (ra == '0)) || rst) begin
        rdata[k] = '0;
        rbusy[k] = 1'b0;
      end
    end
  end

  assign bus.rd_data  = rdata;
  assign bus.rd_busy  = rbusy;
  assign bus.stall    = |(rbusy & bus.rd_en);
  assign bus.busy_cnt = cnt_q;
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-read-port register file for the pipelined MIPS core; successor to the single-cycle two-read/one-write file.
- Adds NUM_RD combinational read ports, a hardwired zero register, and a per-register scoreboard (busy bits).
- Decode marks a destination busy at issue; writeback clears the bit. Hazard flags on each read port drive the stall logic.
- Sits between decode (read/issue) and writeback (write).

Parameters:
- WIDTH, 32, data width of each register.
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1, register 0 reads as 0 and is never written or marked busy.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*WIDTH  read data; port k at bits [k*WIDTH +: WIDTH].
- rd_busy  out  NUM_RD  scoreboard busy flag of the register addressed by port k.
- we  in  1  writeback write enable.
- wa  in  ADDR_W  writeback address.
- wd  in  WIDTH  writeback data.
- iss_valid  in  1  issue strobe: mark iss_addr busy.
- iss_addr  in  ADDR_W  destination register of the issuing instruction.
- stall  out  1  OR of rd_busy over all ports whose rd_en bit is set.
- rd_en  in  NUM_RD  per-port "operand actually used" qualifier for stall.
- busy_cnt  out  ADDR_W+1  number of registers currently busy.

Behaviour:
- Reset (rst=1, asynchronous): all DEPTH registers <= 0; all busy bits <= 0; busy_cnt = 0.
  - While in reset, rd_data = 0, rd_busy = 0, stall = 0.
  - Reset release is synchronous to clk; the first write is accepted on the first rising edge with rst=0.
- Read:
  - Purely combinational; zero-cycle latency from rd_addr.
  - With ZERO_REG=1, address 0 returns 0 and rd_busy = 0 regardless of stored state.
- Write:
  - On posedge clk with we=1, reg[wa] <= wd.
  - With ZERO_REG=1 and wa=0, the write is dropped.
- Scoreboard, per register r, evaluated at posedge clk:
  - set = iss_valid && iss_addr==r; clr = we && wa==r.
  - set && clr: busy stays/becomes 1 (the new producer wins over the old writeback).
  - set only: busy <= 1. Issuing an already-busy register is legal (WAW); it stays 1.
  - clr only: busy <= 0.
  - Register 0 never becomes busy when ZERO_REG=1.
- busy_cnt:
  - Registered; equals the popcount of busy bits after each edge.
  - Updated incrementally: +1 on a set of a non-busy register, -1 on a clr without set of a busy register; net 0 when both occur on different registers.
  - Never exceeds DEPTH-ZERO_REG.
- stall: combinational, = |(rd_busy & rd_en).
- Multiple read ports may address the same register; each returns identical data and busy.

Optional Feature:
- Macro REGFILE_WB_BYPASS_EN.
- Defined:
  - A read port whose address equals wa while we=1 returns wd in the same cycle (write-through forwarding).
  - rd_busy for that port is forced to 0 unless iss_valid targets the same register that cycle.
  - The zero-register rule still has priority.
- Undefined:
  - Reads return the pre-edge stored value.
  - rd_busy reflects the stored busy bit only, so the consumer stalls one extra cycle after writeback.

Test Plan:
- Reset with rst=1 mid-run after writing reg5=0xDEADBEEF, then release → every port reads 0, busy_cnt=0, stall=0.
- we=1, wa=0, wd=0x1234; then rd_addr port0=0 → rd_data=0, rd_busy=0 (ZERO_REG=1); port1 at reg0 also 0.
- iss_valid at reg7 in cycle 1; rd_addr=7 with rd_en=1 → rd_busy=1, stall=1, busy_cnt=1; writeback we, wa=7, wd=0xA5A5A5A5 in cycle 3 → next cycle rd_data=0xA5A5A5A5, rd_busy=0, busy_cnt=0.
- Same-cycle iss_valid at reg9 and we, wa=9, wd=0x11 → reg9=0x11, busy stays 1, busy_cnt unchanged at 1.
- With REGFILE_WB_BYPASS_EN: reg3 busy; in the same cycle we, wa=3, wd=0x55 and rd_addr=3 → rd_data=0x55, rd_busy=0, stall=0. Without the macro → old value, stall=1.
- NUM_RD=4: all ports read distinct registers 1..4 preloaded 0x1..0x4 → rd_data fields equal 0x1..0x4 in port order; rd_en=0 on a busy port → stall=0.
